ibus_mem_responder: RTL

//  Memory-side responder for the instruction bus (ibus_req_t / ibus_resp_t).

---
 rtl/ibus_mem_responder.sv | 115 +++++++++++
 1 files changed

// File: rtl/ibus_mem_responder.sv
// ibus_mem_responder
// Memory-side endpoint of the instruction bus. Fetches are served from a
// word-organised array after a fixed number of wait states. A preload port
// lets the loader fill the array. Addresses outside the window return FILL.
module ibus_mem_responder #(
    parameter int          LATENCY = 2,
    parameter int          DEPTH   = 1024,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter logic [31:0] FILL    = 32'h0000_0013,
    localparam int         AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,          // asynchronous, active low
    input  logic          ireq_valid,
    input  logic [63:0]   ireq_addr,
    output logic          iresp_addr_ok,
    output logic          iresp_data_ok,
    output logic [31:0]   iresp_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [31:0]   wr_data
);

    // cnt only ever holds LATENCY-1 down to 1, so this width is enough.
    localparam int          CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [63:0] SPAN  = 64'(4 * DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [63:0]   addr_q, addr_n;
    logic          addr_ok, data_ok;

    logic [31:0]   mem [DEPTH];
    logic [63:0]   off;
    logic          in_range;
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_word;
    logic          req_match;

    // Preload port; the array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    // Window check uses the offset so BASE+4*DEPTH never has to be formed and
    // cannot wrap; low two address bits are dropped, giving aligned reads.
    always_comb begin
        off       = addr_q - BASE;
        in_range  = (addr_q >= BASE) && (off < SPAN);
        rd_idx    = off[AW+1:2];
        rd_word   = in_range ? mem[rd_idx] : FILL;
        req_match = ireq_valid && (ireq_addr == addr_q);
    end

    // State, wait counter and captured request address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            addr_q <= addr_n;
        end
    end

    // Next state and handshake strobes. A flush or redirect while a fetch is
    // in flight drops back to IDLE; the new request is taken there next cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        addr_n  = addr_q;
        addr_ok = 1'b0;
        data_ok = 1'b0;
        case (state)
            IDLE: begin
                if (ireq_valid) begin
                    addr_ok = 1'b1;
                    addr_n  = ireq_addr;
                    cnt_n   = CW'(LATENCY - 1);
                    state_n = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (!req_match) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                    if (cnt == CW'(1)) state_n = RESP;
                end
            end
            RESP: begin
                data_ok = req_match;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are gated by reset so they fall as soon as reset asserts,
    // without waiting for the state register to be observed.
    always_comb begin
        iresp_addr_ok = addr_ok & reset;
        iresp_data_ok = data_ok & reset;
        iresp_data    = (data_ok & reset) ? rd_word : 32'h0;
    end

endmodule
